// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types, direction encodings and west data collector constants.
// Direction macros are guarded so an existing project-wide definition takes precedence.
`ifndef VEC_CACHE_NORTH
`define VEC_CACHE_NORTH 2'd0
`endif
`ifndef VEC_CACHE_EAST
`define VEC_CACHE_EAST 2'd1
`endif
`ifndef VEC_CACHE_SOUTH
`define VEC_CACHE_SOUTH 2'd2
`endif
`ifndef VEC_CACHE_WEST
`define VEC_CACHE_WEST 2'd3
`endif

package vector_cache_pkg;

  localparam int VEC_CACHE_CHN_NUM                = 8;
  localparam int VEC_CACHE_CHN_W                  = $clog2(VEC_CACHE_CHN_NUM);
  localparam int VEC_CACHE_COLLECTOR_DEPTH        = 4;
  localparam int VEC_CACHE_COLLECTOR_AFULL_MARGIN = 1;
  localparam int VEC_CACHE_DIR_W                  = 2;

  typedef struct packed {
    logic [VEC_CACHE_DIR_W-1:0] direction_id;
    logic [5:0]                 rob_id;
  } txnid_t;

  typedef struct packed {
    txnid_t     txnid;
    logic [7:0] way_tag;
  } cmd_pld_t;

  typedef struct packed {
    cmd_pld_t    cmd_pld;
    logic [31:0] data;
  } data_pld_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // First requesting lane at or after ptr, wrapping; returns ptr when nothing requests.
  function automatic logic [VEC_CACHE_CHN_W-1:0] rr_pick(
    input logic [VEC_CACHE_CHN_NUM-1:0] req,
    input logic [VEC_CACHE_CHN_W-1:0]   ptr
  );
    logic [VEC_CACHE_CHN_W-1:0] idx;
    logic [VEC_CACHE_CHN_W-1:0] pick;
    logic                       hit;
    pick = ptr;
    hit  = 1'b0;
    for (int k = 0; k < VEC_CACHE_CHN_NUM; k++) begin
      idx = ptr + VEC_CACHE_CHN_W'(k);
      if (!hit && req[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/vec_cache_lane_fifo.sv
// Single-clock per-lane FIFO; the head is read straight from registered storage
// so downstream output logic never sees a path from the write side.
module vec_cache_lane_fifo
  import vector_cache_pkg::*;
#(
  parameter  int DEPTH = VEC_CACHE_COLLECTOR_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  data_pld_t        push_data_i,
  input  logic             pop_i,
  output data_pld_t        head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_next_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  data_pld_t        mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full lane still accepts a push when its head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_next_o = count_d;

endmodule

// File: rtl/vec_cache_west_data_collector.sv
// Buffers the eight west-edge read-return lanes and merges them with a locked round-robin arbiter.
// Optional direction filtering is enabled by defining VEC_CACHE_COLLECTOR_DIR_CHECK_EN.
module vec_cache_west_data_collector
  import vector_cache_pkg::*;
#(
  parameter int FIFO_DEPTH   = VEC_CACHE_COLLECTOR_DEPTH,
  parameter int AFULL_MARGIN = VEC_CACHE_COLLECTOR_AFULL_MARGIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [VEC_CACHE_CHN_NUM-1:0] data_in_vld,
  input  data_pld_t                    data_in [VEC_CACHE_CHN_NUM],
  output logic                         data_out_vld,
  input  logic                         data_out_rdy,
  output data_pld_t                    data_out,
  output logic [VEC_CACHE_CHN_W-1:0]   data_out_chan,
  output logic [VEC_CACHE_CHN_NUM-1:0] almost_full,
  output logic [VEC_CACHE_CHN_NUM-1:0] overflow_err,
  output logic [VEC_CACHE_CHN_NUM-1:0] dir_err
);

  localparam int              CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] AFULL_THR = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);

  logic [VEC_CACHE_CHN_NUM-1:0] lane_empty, lane_full, lane_push, lane_pop, dir_ok;
  data_pld_t                    lane_head     [VEC_CACHE_CHN_NUM];
  logic [CNT_W-1:0]             lane_cnt_next [VEC_CACHE_CHN_NUM];

  arb_state_e                   arb_state_q;
  logic [VEC_CACHE_CHN_W-1:0]   grant_q, rr_ptr_q, grant;
  logic                         handshake;
  logic [VEC_CACHE_CHN_NUM-1:0] afull_q, overflow_q;

  for (genvar gi = 0; gi < VEC_CACHE_CHN_NUM; gi++) begin : g_lane
`ifdef VEC_CACHE_COLLECTOR_DIR_CHECK_EN
    assign dir_ok[gi] = (data_in[gi].cmd_pld.txnid.direction_id == `VEC_CACHE_WEST);
`else
    assign dir_ok[gi] = 1'b1;
`endif
    assign lane_push[gi] = data_in_vld[gi] && dir_ok[gi];
    assign lane_pop[gi]  = handshake && (grant == VEC_CACHE_CHN_W'(gi));

    vec_cache_lane_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (lane_push[gi]),
      .push_data_i  (data_in[gi]),
      .pop_i        (lane_pop[gi]),
      .head_o       (lane_head[gi]),
      .empty_o      (lane_empty[gi]),
      .full_o       (lane_full[gi]),
      .count_next_o (lane_cnt_next[gi])
    );
  end

  // While locked the grant is frozen; a locked lane cannot drain, so it stays non-empty.
  assign grant        = (arb_state_q == ARB_LOCKED) ? grant_q : rr_pick(~lane_empty, rr_ptr_q);
  assign data_out_vld = |(~lane_empty);
  assign handshake    = data_out_vld && data_out_rdy;
  assign data_out      = data_out_vld ? lane_head[grant] : '0;
  assign data_out_chan = data_out_vld ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state_q <= ARB_OPEN;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
    end else if (handshake) begin
      arb_state_q <= ARB_OPEN;
      grant_q     <= grant;
      rr_ptr_q    <= grant + 1'b1;
    end else if (data_out_vld) begin
      arb_state_q <= ARB_LOCKED;
      grant_q     <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q    <= '0;
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < VEC_CACHE_CHN_NUM; i++) begin
        afull_q[i] <= (lane_cnt_next[i] >= AFULL_THR);
      end
      overflow_q <= overflow_q | (lane_push & lane_full & ~lane_pop);
    end
  end

`ifdef VEC_CACHE_COLLECTOR_DIR_CHECK_EN
  logic [VEC_CACHE_CHN_NUM-1:0] dir_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_err_q <= '0;
    else        dir_err_q <= dir_err_q | (data_in_vld & ~dir_ok);
  end

  assign dir_err = dir_err_q;
`else
  assign dir_err = '0;
`endif

  assign almost_full  = afull_q;
  assign overflow_err = overflow_q;

endmodule
